// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 peripheral that writes a small register file from serial frames.
// Optional register reads over CIPO are built in when SPI_READBACK_EN is defined.
module spi_regfile_peripheral #(
    parameter int NUM_REGS    = 5,
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       SCLK,
    input  logic                       COPI,
    input  logic                       nCS,
    output logic                       CIPO,
    output logic                       cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs_out,
    output logic                       wr_stb,
    output logic [ADDR_W-1:0]          wr_addr
);
    localparam int F     = 1 + ADDR_W + DATA_W;
    localparam int CNT_W = $clog2(F + 2);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_copi_sync;
    logic [SYNC_STAGES-1:0] r_ncs_sync;
    logic                   r_sclk_d;
    logic                   r_ncs_d;
    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [F-1:0]           r_shift;
    logic [DATA_W-1:0]      r_regs [NUM_REGS];

    logic              w_sclk;
    logic              w_copi;
    logic              w_ncs;
    logic              w_sclk_rise;
    logic              w_ncs_fall;
    logic              w_ncs_rise;
    logic [F-1:0]      w_shift_nx;
    logic              w_rw;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic              w_in_range;
    logic              w_commit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sclk_sync <= '0;
            r_copi_sync <= '0;
            r_ncs_sync  <= '0;
            r_sclk_d    <= 1'b0;
            r_ncs_d     <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SCLK};
            r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], COPI};
            r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0], nCS};
            r_sclk_d    <= w_sclk;
            r_ncs_d     <= w_ncs;
        end
    end

    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_copi      = r_copi_sync[SYNC_STAGES-1];
    assign w_ncs       = r_ncs_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk & ~r_sclk_d;
    assign w_ncs_fall  = ~w_ncs & r_ncs_d;
    assign w_ncs_rise  = w_ncs & ~r_ncs_d;

    assign w_shift_nx = {r_shift[F-2:0], w_copi};
    assign w_rw       = r_shift[F-1];
    assign w_addr     = r_shift[DATA_W +: ADDR_W];
    assign w_data     = r_shift[DATA_W-1:0];
    assign w_in_range = 32'(w_addr) < NUM_REGS;
    assign w_commit   = (r_cnt == CNT_W'(F)) && w_rw && w_in_range;

    // Counter saturates at F+1 so any overlong frame stays distinguishable.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
            wr_stb  <= 1'b0;
            wr_addr <= '0;
            for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= '0;
        end else begin
            wr_stb <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_ncs_fall) begin
                        r_state <= SHIFT;
                        r_cnt   <= '0;
                        r_shift <= '0;
                    end
                end
                SHIFT: begin
                    if (w_sclk_rise) begin
                        r_shift <= w_shift_nx;
                        if (r_cnt != CNT_W'(F + 1)) r_cnt <= r_cnt + CNT_W'(1);
                    end
                    if (w_ncs_rise) r_state <= COMMIT;
                end
                COMMIT: begin
                    if (w_commit) begin
                        wr_stb  <= 1'b1;
                        wr_addr <= w_addr;
                        for (int k = 0; k < NUM_REGS; k++) begin
                            if (w_addr == ADDR_W'(k)) r_regs[k] <= w_data;
                        end
                    end
                    if (w_ncs_fall) begin
                        r_state <= SHIFT;
                        r_cnt   <= '0;
                        r_shift <= '0;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_out
        assign regs_out[k*DATA_W +: DATA_W] = r_regs[k];
    end

`ifdef SPI_READBACK_EN
    logic [DATA_W-1:0] r_oshift;
    logic              r_oe;
    logic [DATA_W-1:0] w_rd_data;
    logic              w_sclk_fall;
    logic              w_rd_load;

    assign w_sclk_fall = ~w_sclk & r_sclk_d;
    assign w_rd_load   = w_sclk_rise && (r_cnt == CNT_W'(ADDR_W))
                         && !w_shift_nx[ADDR_W];

    always_comb begin
        w_rd_data = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (w_shift_nx[ADDR_W-1:0] == ADDR_W'(k)) w_rd_data = r_regs[k];
        end
    end

    // Load on the last address bit so the MSB is ready for the first data rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_oshift <= '0;
            r_oe     <= 1'b0;
        end else if (r_state != SHIFT || w_ncs_rise) begin
            r_oshift <= '0;
            r_oe     <= 1'b0;
        end else if (w_rd_load) begin
            r_oshift <= w_rd_data;
            r_oe     <= 1'b1;
        end else if (r_oe && w_sclk_fall) begin
            r_oshift <= r_oshift << 1;
        end
    end

    assign CIPO    = r_oshift[DATA_W-1];
    assign cipo_oe = r_oe;
`else
    assign CIPO    = 1'b0;
    assign cipo_oe = 1'b0;
`endif
endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Randomized bench for spi_regfile_peripheral with a register-file reference model.
module tb_spi_regfile_peripheral;
    localparam int NR  = 5;
    localparam int AW  = 7;
    localparam int DW  = 8;
    localparam int SS  = 2;
    localparam int F   = 1 + AW + DW;
    localparam int NR2 = 16;
    localparam int AW2 = 4;
    localparam int DW2 = 16;
    localparam int F2  = 1 + AW2 + DW2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sclk = 1'b0, copi = 1'b0, ncs = 1'b1;
    logic CIPO, cipo_oe, wr_stb;
    logic [NR*DW-1:0] regs_out;
    logic [AW-1:0]    wr_addr;
    logic sclk2 = 1'b0, copi2 = 1'b0, ncs2 = 1'b1;
    logic cipo2, oe2, stb2;
    logic [NR2*DW2-1:0] regs2;
    logic [AW2-1:0]     waddr2;

    int n_chk  = 0;
    int n_fail = 0;
    bit busy   = 1'b1;
    logic [DW-1:0] mdl [NR];

    spi_regfile_peripheral #(
        .NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW), .SYNC_STAGES(SS)
    ) u_dut (
        .clk(clk), .rst(rst), .SCLK(sclk), .COPI(copi), .nCS(ncs),
        .CIPO(CIPO), .cipo_oe(cipo_oe), .regs_out(regs_out),
        .wr_stb(wr_stb), .wr_addr(wr_addr)
    );

    spi_regfile_peripheral #(
        .NUM_REGS(NR2), .ADDR_W(AW2), .DATA_W(DW2), .SYNC_STAGES(SS)
    ) u_dut2 (
        .clk(clk), .rst(rst), .SCLK(sclk2), .COPI(copi2), .nCS(ncs2),
        .CIPO(cipo2), .cipo_oe(oe2), .regs_out(regs2),
        .wr_stb(stb2), .wr_addr(waddr2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    function automatic logic [NR*DW-1:0] mflat();
        logic [NR*DW-1:0] v;
        v = '0;
        for (int k = 0; k < NR; k++) v[k*DW +: DW] = mdl[k];
        return v;
    endfunction

    always @(negedge clk) begin
        if (!busy) begin
            chk("idle_regs", 64'(regs_out), 64'(mflat()));
            chk("idle_stb", 64'(wr_stb), 64'(0));
            chk("idle_oe", 64'(cipo_oe), 64'(0));
            chk("idle_stb2", 64'(stb2), 64'(0));
            chk("idle_oe2", 64'({cipo2, oe2}), 64'(0));
        end
`ifndef SPI_READBACK_EN
        chk("cipo_tied", 64'({CIPO, cipo_oe}), 64'(0));
`endif
    end

    task automatic frame(input int which, input logic [31:0] bits, input int n,
                         input int rst_at, output logic [31:0] rd);
        int f, dw, nr, addr, pulses, first;
        logic rw, s, expw;
        logic [31:0] data;
        busy = 1'b1;
        rd = '0;
        @(negedge clk);
        if (which == 0) ncs = 1'b0; else ncs2 = 1'b0;
        repeat (5) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            if (which == 0) copi = bits[n-1-i]; else copi2 = bits[n-1-i];
            repeat (5) @(negedge clk);
            if (which == 0 && i > AW) rd = {rd[30:0], CIPO};
            if (which == 0) sclk = 1'b1; else sclk2 = 1'b1;
            repeat (5) @(negedge clk);
            if (which == 0) sclk = 1'b0; else sclk2 = 1'b0;
            if (i + 1 == rst_at) begin
                rst = 1'b1;
                repeat (2) @(negedge clk);
                rst = 1'b0;
                foreach (mdl[k]) mdl[k] = '0;
            end
        end
        repeat (5) @(negedge clk);
        if (which == 0) ncs = 1'b1; else ncs2 = 1'b1;
        f  = (which == 0) ? F : F2;
        dw = (which == 0) ? DW : DW2;
        nr = (which == 0) ? NR : NR2;
        rw   = bits[f-1];
        addr = int'((bits >> dw) & ((32'd1 << (f - 1 - dw)) - 1));
        data = bits & ((32'd1 << dw) - 1);
        expw = (n == f) && rw && (addr < nr) && (rst_at == 0);
        if (expw && which == 0) mdl[addr] = data[DW-1:0];
        pulses = 0;
        first  = 0;
        for (int c = 1; c <= SS + 4; c++) begin
            @(negedge clk);
            s = (which == 0) ? wr_stb : stb2;
            if (s) begin
                pulses++;
                if (first == 0) first = c;
                if (which == 0) begin
                    chk("stb_addr", 64'(wr_addr), 64'(addr));
                    chk("stb_regs", 64'(regs_out), 64'(mflat()));
                end else begin
                    chk("stb_addr2", 64'(waddr2), 64'(addr));
                end
            end
        end
        chk("stb_count", 64'(pulses), 64'(expw));
        if (expw) chk("latency", 64'(first > 0 && first <= SS + 2), 64'(1));
        busy = 1'b0;
    endtask

    initial begin
        logic [31:0] rd, bits, frm;
        logic [7:0]  exp_rd;
        int n, rw, addr, data, sel;
        foreach (mdl[k]) mdl[k] = '0;
        repeat (3) @(negedge clk);
        chk("rst_regs", 64'(regs_out), 64'(0));
        chk("rst_stb", 64'({wr_stb, wr_addr}), 64'(0));
        chk("rst_cipo", 64'({CIPO, cipo_oe}), 64'(0));
        chk("rst_regs2", 64'(regs2[63:0]), 64'(0));
        rst = 1'b0;
        repeat (6) @(negedge clk);
        busy = 1'b0;

        frame(0, 32'h8255, 16, 0, rd);
        chk("wr_lit", 64'(regs_out), 64'h55_0000);
        frame(0, 32'h40AA, 15, 0, rd);
        chk("len15_r1", 64'(regs_out[15:8]), 64'(0));
        frame(0, 32'h102AB, 17, 0, rd);
        chk("len17_r1", 64'(regs_out[15:8]), 64'(0));
        frame(0, 32'h85AA, 16, 0, rd);
        chk("oor_lit", 64'(regs_out), 64'h55_0000);
        frame(0, 32'h84C3, 16, 0, rd);
        chk("wr4_lit", 64'(regs_out), 64'hC3_0055_0000);
        frame(0, 32'h0400, 16, 0, rd);
`ifdef SPI_READBACK_EN
        chk("rd4_lit", 64'(rd[7:0]), 64'hC3);
`else
        chk("rd4_off", 64'(rd[7:0]), 64'h00);
`endif
        chk("rd_oe_after", 64'(cipo_oe), 64'(0));
        chk("rd4_keep", 64'(regs_out[39:32]), 64'hC3);
        frame(0, 32'h807E, 16, 0, rd);
        frame(0, 32'h8011, 16, 10, rd);
        chk("rst_mid", 64'(regs_out), 64'(0));
        frame(0, 32'h8011, 16, 0, rd);
        chk("after_rst", 64'(regs_out), 64'h11);

        for (int t = 0; t < 60; t++) begin
            rw   = $urandom_range(0, 1);
            addr = $urandom_range(0, 7);
            data = $urandom_range(0, 255);
            frm  = (32'(rw) << 15) | (32'(addr) << 8) | 32'(data);
            sel  = $urandom_range(0, 9);
            if (sel == 0) begin
                n = F - 1;
                bits = frm >> 1;
            end else if (sel == 1) begin
                n = F + 1;
                bits = (frm << 1) | 32'($urandom_range(0, 1));
            end else begin
                n = F;
                bits = frm;
            end
`ifdef SPI_READBACK_EN
            exp_rd = (addr < NR) ? mdl[addr] : 8'h00;
`else
            exp_rd = 8'h00;
`endif
            frame(0, bits, n, 0, rd);
            if (n == F && rw == 0) chk("rd_rand", 64'(rd[7:0]), 64'(exp_rd));
        end

        frame(1, 32'h1FBEEF, 21, 0, rd);
        chk("sweep_r15", 64'(regs2[255:240]), 64'hBEEF);
        chk("sweep_low", 64'(regs2[63:0]), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_regfile_peripheral.md
SPI_REGFILE_PERIPHERAL -- requirements
Module: spi_regfile_peripheral

Interface
REQ-001 SHALL have parameter NUM_REGS, default 5, number of data registers (1..2**ADDR_W).
REQ-002 SHALL have parameter ADDR_W, default 7, address field width in bits.
REQ-003 SHALL have parameter DATA_W, default 8, register and data field width in bits.
REQ-004 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth (>=2) on SCLK, COPI and nCS.
REQ-005 SHALL have port clk  input  1  the single system clock; all logic is clocked on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port SCLK  input  1  asynchronous SPI clock, mode 0, at most clk/8.
REQ-008 SHALL have port COPI  input  1  asynchronous serial data in, MSB first.
REQ-009 SHALL have port nCS  input  1  asynchronous active-low chip select.
REQ-010 SHALL have port CIPO  output  1  serial read data out.
REQ-011 SHALL have port cipo_oe  output  1  CIPO output enable, high only while nCS is low during a read frame.
REQ-012 SHALL have port regs_out  output  NUM_REGS*DATA_W  flattened register file; register k occupies bits [k*DATA_W +: DATA_W].
REQ-013 SHALL have port wr_stb  output  1  one-cycle pulse per committed write.
REQ-014 SHALL have port wr_addr  output  ADDR_W  address of the last committed write, valid while wr_stb is high.

Function
REQ-015 SHALL process a frame of F = 1+ADDR_W+DATA_W bits: bit 0 R/W (1 = write), then the address MSB first, then the data MSB first.
REQ-016 SHALL sample COPI on each synchronized SCLK rising edge while synchronized nCS is low, and count these edges in a counter wide enough to hold F+1 without wrap.
REQ-017 SHALL use a state machine: IDLE -> SHIFT on the nCS falling edge, which clears the counter and shift register; SHIFT -> COMMIT on the nCS rising edge; COMMIT -> IDLE after exactly one cycle.
REQ-018 SHALL commit a write in COMMIT only if the bit count equals F exactly, R/W=1 and address < NUM_REGS; it updates the register and pulses wr_stb for one cycle.
REQ-019 SHALL discard frames with a bit count other than F, leaving all registers unchanged and keeping wr_stb low.
REQ-020 SHALL discard writes with address >= NUM_REGS, with no register change and no wr_stb.
REQ-021 SHALL make the register update visible on regs_out, together with wr_stb, no more than SYNC_STAGES+2 clk cycles after nCS rises at the pin.
REQ-022 SHALL process an SCLK rising edge and the nCS rising edge that are synchronized in the same cycle with the SCLK edge counted first.
REQ-023 SHALL ignore SCLK edges and COPI while synchronized nCS is high.
REQ-024 SHALL start a new frame cleanly when nCS falls in the cycle immediately after COMMIT; no state carries over from the previous frame.

Reset
REQ-025 SHALL, with rst high at a clk rising edge, clear all regs_out bits, wr_stb, wr_addr, CIPO, cipo_oe, the counters, the shift registers and the synchronizer flops to 0, and set the state to IDLE.
REQ-026 SHALL abort any frame in progress when rst is asserted; the aborted frame commits nothing, and the next frame is recognized only after a fresh nCS falling edge.

Configuration
REQ-027 SHALL, with macro SPI_READBACK_EN defined, support reads (R/W=0): after the last address bit is sampled, load the addressed register (0 if address >= NUM_REGS) into an output shifter, drive its MSB on CIPO, and shift on each subsequent synchronized SCLK falling edge. Reads have no side effects.
REQ-028 SHALL, with SPI_READBACK_EN undefined, tie CIPO and cipo_oe to 0, omit the output shifter, and discard read frames with no side effects.

Verification
REQ-029 SHALL cover a write: 16-bit frame 0x8255 -> register 2 = 0x55 and wr_stb pulses once with wr_addr = 2; all other registers stay 0.
REQ-030 SHALL cover a bad length: 15-bit frame or 17-bit frame with write to address 1 -> no wr_stb, register 1 unchanged.
REQ-031 SHALL cover an out-of-range address: frame 0x85AA with NUM_REGS = 5 -> no wr_stb, regs_out unchanged.
REQ-032 SHALL cover readback with SPI_READBACK_EN defined: write 0xC3 to register 4, then frame 0x0400 -> CIPO bits 1,1,0,0,0,0,1,1 sampled on data SCLK rises; cipo_oe is low after nCS rises; register 4 still = 0xC3.
REQ-033 SHALL cover reset mid-frame: assert rst after 10 bits of a write to register 0 -> regs_out = 0, and the following complete write of 0x11 to register 0 succeeds.
REQ-034 SHALL cover parameter sweep NUM_REGS = 16, DATA_W = 16, ADDR_W = 4: 21-bit write of 0xBEEF to register 15 -> regs_out[255:240] = 0xBEEF.
